// File: rtl/mux_8to1_rr_arbiter_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
//   state_t     : arbiter FSM state (IDLE / GRANT)
//   N_REQ       : number of requesters
//   SEL_W       : width of a requester index
//   RESET_LAST  : pointer value after reset, so requester 0 wins first
//   onehot()    : index -> one-hot grant vector
package mux_8to1_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] RESET_LAST = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_8to1_rr_arbiter_rr_pick8.sv
// Combinational round-robin pick over 8 requests.
//   req  : request vector
//   last : previous winner (lowest priority)
//   pick : first set bit scanning upward from last+1 with wrap 7->0
//   any  : at least one request present
module rr_pick8
    import mux_8to1_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Offset 8 wraps to last itself, so the previous winner is checked last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        any   = |req;
        for (int k = 1; k <= 8; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_8to1_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux among 8 requesters.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester level request
//   in        : per-requester data bit
//   gnt       : registered one-hot grant (zero when idle)
//   sel       : registered index of current/last grantee
//   busy      : registered, equals |gnt
//   out       : registered in[sel] sampled during a granted cycle
//   out_valid : out carries data from an active grant
module mux_8to1_rr_arbiter
    import mux_8to1_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             out,
    output logic             out_valid
);

    state_t            state, state_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_d;
    logic [SEL_W-1:0]  sel_d;
    logic              busy_d;
    logic              out_d;
    logic              out_valid_d;

    logic [SEL_W-1:0]  pick_base;
    logic [SEL_W-1:0]  pick;
    logic              any;
    logic              hold_ok;

    // While granted, a release re-arbitrates as if last were already sel.
    assign pick_base = (state == ST_GRANT) ? sel : last_q;

    rr_pick8 u_pick (
        .req  (req),
        .last (pick_base),
        .pick (pick),
        .any  (any)
    );

    assign hold_ok = (MAX_HOLD == 0) || (hold_q < HOLD_W'(MAX_HOLD));

    // Next-state, grant and data-path logic.
    always_comb begin
        state_d     = state;
        last_d      = last_q;
        hold_d      = hold_q;
        gnt_d       = gnt;
        sel_d       = sel;
        busy_d      = busy;
        out_d       = out;
        out_valid_d = 1'b0;

        if (state == ST_GRANT) begin
            out_d       = in[sel];
            out_valid_d = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(pick);
                    sel_d   = pick;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (req[sel] && hold_ok) begin
                    if (hold_q != '1) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    last_d = sel;
                    if (any) begin
                        gnt_d  = onehot(pick);
                        sel_d  = pick;
                        busy_d = 1'b1;
                        hold_d = HOLD_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_q    <= RESET_LAST;
            hold_q    <= '0;
            gnt       <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt       <= gnt_d;
            sel       <= sel_d;
            busy      <= busy_d;
            out       <= out_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mux_8to1_rr_arbiter.sv
// Self-checking bench for mux_8to1_rr_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_mux_8to1_rr_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       out;
    logic       out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: owner = -1 when idle.
    int m_owner = -1;
    int m_sel   = 0;
    int m_last  = 7;
    int m_hold  = 0;
    bit m_out   = 1'b0;
    bit m_valid = 1'b0;

    mux_8to1_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in        (in),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin scan: first requester after 'from', wrapping, 'from' itself last.
    function automatic int scan(input logic [7:0] rq, input int from);
        for (int k = 1; k <= 8; k++) begin
            int j;
            j = (from + k) % 8;
            if (rq[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [7:0] rq, input logic [7:0] d);
        bit keep;
        if (r) begin
            m_owner = -1; m_sel = 0; m_last = 7; m_hold = 0;
            m_out = 1'b0; m_valid = 1'b0;
            return;
        end
        if (m_owner >= 0) begin
            m_out   = d[m_sel];
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            if (rq != 0) begin
                m_owner = scan(rq, m_last);
                m_sel   = m_owner;
                m_hold  = 1;
            end
        end else begin
            keep = rq[m_owner] && (MAX_HOLD == 0 || m_hold < int'(MAX_HOLD));
            if (keep) begin
                if (m_hold < 255) m_hold++;
            end else begin
                m_last = m_owner;
                if (rq != 0) begin
                    m_owner = scan(rq, m_last);
                    m_sel   = m_owner;
                    m_hold  = 1;
                end else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("sel", 32'(sel), 32'(m_sel));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out", 32'(out), 32'(m_out));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    // Drive one cycle of inputs, advance one edge, then compare at the falling edge.
    task automatic cycle(input bit r, input logic [7:0] rq, input logic [7:0] d);
        rst = r;
        req = rq;
        in  = d;
        @(posedge clk);
        model_step(r, rq, d);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [7:0] rq_prev;
        logic [7:0] rq_new;
        bit         r_rand;

        rst = 1'b1;
        req = 8'h00;
        in  = 8'h00;
        @(negedge clk);

        // Reset with all requesting: nothing granted, then requester 0 first.
        cycle(1'b1, 8'hFF, 8'h00);
        cycle(1'b1, 8'hFF, 8'h00);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        cycle(1'b0, 8'hFF, 8'h00);
        check("first_gnt", 32'(gnt), 32'h01);

        // Full rotation: each owner exactly MAX_HOLD cycles, back to 0 after 32.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 8'hFF, 8'($urandom));
            if (i == 3) check("rot_gnt1", 32'(gnt), 32'h02);
            if (i == 27) check("rot_gnt7", 32'(gnt), 32'h80);
        end
        check("rot_wrap", 32'(gnt), 32'h01);

        // Single requester 3 with its data bit high.
        cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00);
        check("idle_valid", 32'(out_valid), 32'h0);
        cycle(1'b0, 8'h08, 8'h08);
        check("single_gnt", 32'(gnt), 32'h08);
        check("single_sel", 32'(sel), 32'd3);
        cycle(1'b0, 8'h08, 8'h08);
        check("single_out", 32'({out, out_valid}), 32'b11);
        cycle(1'b0, 8'h08, 8'h08);
        cycle(1'b0, 8'h00, 8'h08);
        check("single_drop_gnt", 32'(gnt), 32'h0);
        check("single_drop_valid", 32'(out_valid), 32'h1);
        cycle(1'b0, 8'h00, 8'h08);
        check("single_tail_valid", 32'(out_valid), 32'h0);
        check("single_sel_kept", 32'(sel), 32'd3);

        // Wrap-around: 6 released, then 0 wins over 6.
        cycle(1'b0, 8'h40, 8'h00);
        check("wrap_gnt6", 32'(gnt), 32'h40);
        cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b0, 8'h41, 8'h00);
        check("wrap_gnt0", 32'(gnt), 32'h01);
        cycle(1'b0, 8'h40, 8'h00);
        check("wrap_back6", 32'(gnt), 32'h40);

        // Handoff 2 -> 5 with no idle gap.
        cycle(1'b0, 8'h04, 8'h00);
        check("hand_gnt2", 32'(gnt), 32'h04);
        cycle(1'b0, 8'h20, 8'h00);
        check("hand_gnt5", 32'(gnt), 32'h20);
        check("hand_sel5", 32'(sel), 32'd5);
        check("hand_busy", 32'(busy), 32'h1);

        // Reset mid-grant restores pointer to 7.
        cycle(1'b0, 8'h10, 8'hFF);
        check("midrst_pre", 32'(gnt), 32'h10);
        cycle(1'b1, 8'h11, 8'hFF);
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_out", 32'({out, out_valid}), 32'b00);
        cycle(1'b0, 8'h11, 8'hFF);
        check("midrst_first", 32'(gnt), 32'h01);

        // Lone requester after hold expiry is re-granted with no gap.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 8'h01, 8'($urandom));
            check("lone_regrant", 32'(gnt), 32'h01);
        end

        // Randomized traffic with occasional resets.
        rq_prev = 8'h00;
        for (int i = 0; i < 600; i++) begin
            rq_new  = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) != 0) rq_new = rq_prev;
            if ($urandom_range(0, 9) == 0) rq_new = 8'h00;
            r_rand  = ($urandom_range(0, 63) == 0);
            cycle(r_rand, rq_new, 8'($urandom));
            rq_prev = rq_new;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
